pq_gen2: RTL and testbench

//  Second-generation sorted hardware priority queue: DEPTH-entry shift-array.

---
 rtl/pq_gen2.sv | 270 +++++++++++++++++++++++++++
 tb/tb_pq_gen2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pq_gen2.sv
// pq_gen2: sorted hardware priority queue built on a DEPTH-entry shift array.
// Entries are (data,id) pairs kept ordered so the "best" key is at index 0.
// "Best" means the smallest key when MAX_MODE=0 and the largest when MAX_MODE=1.
// Equal keys keep arrival order.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   push_i, data_i                 push request and key
//   push_rdy_o, push_id_o          push ready; id the next accepted push gets
//   pop_i, pop_rdy_o               pop request and ready
//   pop_vld_o, data_o, id_o        registered popped entry (pop_vld_o pulses)
//   drop_i, drop_id_i, drop_rdy_o  remove-by-id request, id, ready
//   drop_done_o, drop_hit_o        drop completion pulse and found flag
//   peek_vld_o/data_o/id_o         current head
//   full_o, empty_o, cnt_o         occupancy status
//   overflow_o, data/id_overflow_o discarded-entry report (pulse + payload)
//
// Valid/ready: a request transfers on a clock edge where both its request
// input and its ready output are high. A drop takes priority, so while
// drop_i is high the push and pop ready outputs are low.
module pq_gen2 #(
  parameter int DEPTH    = 8,
  parameter int DW       = 8,
  parameter int IDW      = 4,
  parameter int MAX_MODE = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  output logic                       push_rdy_o,
  output logic [IDW-1:0]             push_id_o,
  input  logic                       pop_i,
  output logic                       pop_rdy_o,
  output logic                       pop_vld_o,
  output logic [DW-1:0]              data_o,
  output logic [IDW-1:0]             id_o,
  input  logic                       drop_i,
  input  logic [IDW-1:0]             drop_id_i,
  output logic                       drop_rdy_o,
  output logic                       drop_done_o,
  output logic                       drop_hit_o,
  output logic                       peek_vld_o,
  output logic [DW-1:0]              peek_data_o,
  output logic [IDW-1:0]             peek_id_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       overflow_o,
  output logic [DW-1:0]              data_overflow_o,
  output logic [IDW-1:0]             id_overflow_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int NID = 2**IDW;

  if (NID <= DEPTH) begin : g_bad_idw
    $error("pq_gen2: 2**IDW must exceed DEPTH so a free id always exists");
  end

  typedef enum logic [1:0] {S_IDLE, S_DROP_SRCH, S_DROP_CMPCT} state_e;

  state_e              state_q, state_d;
  logic [DW-1:0]       data_q [DEPTH];
  logic [DW-1:0]       data_d [DEPTH];
  logic [IDW-1:0]      id_q   [DEPTH];
  logic [IDW-1:0]      id_d   [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [DEPTH-1:0]    match_q, match_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDW-1:0]      drop_id_q, drop_id_d;
  logic                pop_vld_q, pop_vld_d;
  logic [DW-1:0]       dout_q, dout_d;
  logic [IDW-1:0]      idout_q, idout_d;
  logic                done_q, done_d, hit_q, hit_d;
  logic                ovf_q, ovf_d;
  logic [DW-1:0]       ovf_data_q, ovf_data_d;
  logic [IDW-1:0]      ovf_id_q, ovf_id_d;

  // Base view of the array after an accepted pop (head removed, rest shifted up).
  logic [DW-1:0]       b_data [DEPTH];
  logic [IDW-1:0]      b_id   [DEPTH];
  logic [DEPTH-1:0]    b_vld;
  logic [CW-1:0]       pos;
  logic [NID-1:0]      used;
  logic [IDW-1:0]      free_id;
  logic                full, push_acc, pop_acc, seen;

  function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (MAX_MODE != 0) return a > b;
    else               return a < b;
  endfunction

  // Lowest id not currently held by a valid entry.
  always_comb begin
    used = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) used[id_q[i]] = 1'b1;
    free_id = '0;
    for (int k = NID-1; k >= 0; k--)
      if (!used[k]) free_id = IDW'(k);
  end

  assign full       = (cnt_q == CW'(DEPTH));
  assign push_rdy_o = (state_q == S_IDLE) && !drop_i;
  assign pop_rdy_o  = (state_q == S_IDLE) && !drop_i && (cnt_q != '0);
  assign drop_rdy_o = (state_q == S_IDLE);
  assign push_acc   = push_i && push_rdy_o;
  assign pop_acc    = pop_i && pop_rdy_o;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (pop_acc) begin
        b_data[i] = (i == DEPTH-1) ? '0 : data_q[(i == DEPTH-1) ? i : i+1];
        b_id[i]   = (i == DEPTH-1) ? '0 : id_q[(i == DEPTH-1) ? i : i+1];
        b_vld[i]  = (i == DEPTH-1) ? 1'b0 : vld_q[(i == DEPTH-1) ? i : i+1];
      end else begin
        b_data[i] = data_q[i];
        b_id[i]   = id_q[i];
        b_vld[i]  = vld_q[i];
      end
    end
    // Insert slot: after every entry the new key is not strictly better than,
    // which places it behind existing equal keys.
    pos = '0;
    for (int i = 0; i < DEPTH; i++)
      if (b_vld[i] && !better(data_i, b_data[i])) pos = pos + CW'(1);
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    id_d       = id_q;
    vld_d      = vld_q;
    match_d    = match_q;
    cnt_d      = cnt_q;
    drop_id_d  = drop_id_q;
    pop_vld_d  = 1'b0;
    dout_d     = dout_q;
    idout_d    = idout_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    ovf_d      = 1'b0;
    ovf_data_d = ovf_data_q;
    ovf_id_d   = ovf_id_q;
    seen       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drop_i) begin
          drop_id_d = drop_id_i;
          state_d   = S_DROP_SRCH;
        end else begin
          if (pop_acc) begin
            pop_vld_d = 1'b1;
            dout_d    = data_q[0];
            idout_d   = id_q[0];
          end
          if (push_acc && full && !pop_acc && (pos == CW'(DEPTH))) begin
            // New key is no better than the tail: reject it.
            ovf_d      = 1'b1;
            ovf_data_d = data_i;
            ovf_id_d   = free_id;
          end else if (push_acc) begin
            if (full && !pop_acc) begin
              // Tail falls off the end of the shift below.
              ovf_d      = 1'b1;
              ovf_data_d = b_data[DEPTH-1];
              ovf_id_d   = b_id[DEPTH-1];
            end
            for (int i = 0; i < DEPTH; i++) begin
              if (i == int'(pos)) begin
                data_d[i] = data_i;
                id_d[i]   = free_id;
                vld_d[i]  = 1'b1;
              end else if (i > int'(pos)) begin
                data_d[i] = b_data[(i == 0) ? 0 : i-1];
                id_d[i]   = b_id[(i == 0) ? 0 : i-1];
                vld_d[i]  = b_vld[(i == 0) ? 0 : i-1];
              end else begin
                data_d[i] = b_data[i];
                id_d[i]   = b_id[i];
                vld_d[i]  = b_vld[i];
              end
            end
            if (!full && !pop_acc) cnt_d = cnt_q + CW'(1);
          end else if (pop_acc) begin
            data_d = b_data;
            id_d   = b_id;
            vld_d  = b_vld;
            cnt_d  = cnt_q - CW'(1);
          end
        end
      end
      S_DROP_SRCH: begin
        for (int i = 0; i < DEPTH; i++)
          match_d[i] = vld_q[i] && (id_q[i] == drop_id_q);
        state_d = S_DROP_CMPCT;
      end
      S_DROP_CMPCT: begin
        // Every slot at or after the match takes its successor's contents.
        for (int i = 0; i < DEPTH; i++) begin
          seen = seen | match_q[i];
          if (seen) begin
            data_d[i] = (i == DEPTH-1) ? '0 : data_q[(i == DEPTH-1) ? i : i+1];
            id_d[i]   = (i == DEPTH-1) ? '0 : id_q[(i == DEPTH-1) ? i : i+1];
            vld_d[i]  = (i == DEPTH-1) ? 1'b0 : vld_q[(i == DEPTH-1) ? i : i+1];
          end
        end
        done_d  = 1'b1;
        hit_d   = |match_q;
        if (|match_q) cnt_d = cnt_q - CW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        id_q[i]   <= '0;
      end
      vld_q      <= '0;
      match_q    <= '0;
      cnt_q      <= '0;
      drop_id_q  <= '0;
      pop_vld_q  <= 1'b0;
      dout_q     <= '0;
      idout_q    <= '0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ovf_data_q <= '0;
      ovf_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      id_q       <= id_d;
      vld_q      <= vld_d;
      match_q    <= match_d;
      cnt_q      <= cnt_d;
      drop_id_q  <= drop_id_d;
      pop_vld_q  <= pop_vld_d;
      dout_q     <= dout_d;
      idout_q    <= idout_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      ovf_q      <= ovf_d;
      ovf_data_q <= ovf_data_d;
      ovf_id_q   <= ovf_id_d;
    end
  end

  assign push_id_o       = free_id;
  assign pop_vld_o       = pop_vld_q;
  assign data_o          = dout_q;
  assign id_o            = idout_q;
  assign drop_done_o     = done_q;
  assign drop_hit_o      = hit_q;
  assign peek_vld_o      = vld_q[0];
  assign peek_data_o     = data_q[0];
  assign peek_id_o       = id_q[0];
  assign full_o          = full;
  assign empty_o         = (cnt_q == '0);
  assign cnt_o           = cnt_q;
  assign overflow_o      = ovf_q;
  assign data_overflow_o = ovf_data_q;
  assign id_overflow_o   = ovf_id_q;
endmodule

// File: tb/tb_pq_gen2.sv
// Directed bench for pq_gen2: one min-mode and one max-mode instance share
// the same request inputs; each scenario checks only the instance it targets.
module tb_pq_gen2;
  logic       clk = 1'b0;
  logic       rst_i, push_i, pop_i, drop_i;
  logic [7:0] data_i;
  logic [3:0] drop_id_i;

  // min-mode instance outputs
  logic       mn_push_rdy, mn_pop_rdy, mn_pop_vld, mn_drop_rdy, mn_done, mn_hit;
  logic       mn_peek_vld, mn_full, mn_empty, mn_ovf;
  logic [3:0] mn_push_id, mn_id_o, mn_peek_id, mn_cnt, mn_ovf_id;
  logic [7:0] mn_data_o, mn_peek_data, mn_ovf_data;
  // max-mode instance outputs
  logic       mx_push_rdy, mx_pop_rdy, mx_pop_vld, mx_drop_rdy, mx_done, mx_hit;
  logic       mx_peek_vld, mx_full, mx_empty, mx_ovf;
  logic [3:0] mx_push_id, mx_id_o, mx_peek_id, mx_cnt, mx_ovf_id;
  logic [7:0] mx_data_o, mx_peek_data, mx_ovf_data;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  pq_gen2 #(.DEPTH(8), .DW(8), .IDW(4), .MAX_MODE(0)) u_min (
    .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .data_i(data_i),
    .push_rdy_o(mn_push_rdy), .push_id_o(mn_push_id), .pop_i(pop_i),
    .pop_rdy_o(mn_pop_rdy), .pop_vld_o(mn_pop_vld), .data_o(mn_data_o),
    .id_o(mn_id_o), .drop_i(drop_i), .drop_id_i(drop_id_i),
    .drop_rdy_o(mn_drop_rdy), .drop_done_o(mn_done), .drop_hit_o(mn_hit),
    .peek_vld_o(mn_peek_vld), .peek_data_o(mn_peek_data), .peek_id_o(mn_peek_id),
    .full_o(mn_full), .empty_o(mn_empty), .cnt_o(mn_cnt), .overflow_o(mn_ovf),
    .data_overflow_o(mn_ovf_data), .id_overflow_o(mn_ovf_id));

  pq_gen2 #(.DEPTH(8), .DW(8), .IDW(4), .MAX_MODE(1)) u_max (
    .clk_i(clk), .rst_i(rst_i), .push_i(push_i), .data_i(data_i),
    .push_rdy_o(mx_push_rdy), .push_id_o(mx_push_id), .pop_i(pop_i),
    .pop_rdy_o(mx_pop_rdy), .pop_vld_o(mx_pop_vld), .data_o(mx_data_o),
    .id_o(mx_id_o), .drop_i(drop_i), .drop_id_i(drop_id_i),
    .drop_rdy_o(mx_drop_rdy), .drop_done_o(mx_done), .drop_hit_o(mx_hit),
    .peek_vld_o(mx_peek_vld), .peek_data_o(mx_peek_data), .peek_id_o(mx_peek_id),
    .full_o(mx_full), .empty_o(mx_empty), .cnt_o(mx_cnt), .overflow_o(mx_ovf),
    .data_overflow_o(mx_ovf_data), .id_overflow_o(mx_ovf_id));

  // clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] d);
    push_i = 1'b1; data_i = d;
    tick();
    push_i = 1'b0;
  endtask

  task automatic do_pop();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  // Drop on the min instance with fixed latency: done must be low one edge
  // after acceptance and high on the second.
  task automatic drop_min(input logic [3:0] id, input logic exp_hit, input logic [3:0] exp_cnt);
    drop_i = 1'b1; drop_id_i = id;
    #1;
    check_eq("drop_rdy_idle", 32'(mn_drop_rdy), 32'd1);
    check_eq("pop_rdy_blocked_by_drop", 32'(mn_pop_rdy), 32'd0);
    tick();
    drop_i = 1'b0;
    check_eq("push_rdy_in_srch", 32'(mn_push_rdy), 32'd0);
    tick();
    check_eq("done_early", 32'(mn_done), 32'd0);
    tick();
    check_eq("drop_done", 32'(mn_done), 32'd1);
    check_eq("drop_hit", 32'(mn_hit), 32'(exp_hit));
    check_eq("drop_cnt", 32'(mn_cnt), 32'(exp_cnt));
    tick();
    check_eq("done_pulse_end", 32'(mn_done), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; push_i = 1'b0; pop_i = 1'b0; drop_i = 1'b0;
    data_i = '0; drop_id_i = '0;
    do_reset();

    // reset state
    check_eq("rst_empty", 32'(mn_empty), 32'd1);
    check_eq("rst_full", 32'(mn_full), 32'd0);
    check_eq("rst_cnt", 32'(mn_cnt), 32'd0);
    check_eq("rst_push_id", 32'(mn_push_id), 32'd0);
    check_eq("rst_peek_vld", 32'(mn_peek_vld), 32'd0);
    check_eq("rst_pop_vld", 32'(mn_pop_vld), 32'd0);
    check_eq("rst_data_o", 32'(mn_data_o), 32'd0);
    check_eq("rst_ovf", 32'(mn_ovf), 32'd0);

    // pop on empty is not accepted
    check_eq("pop_rdy_empty", 32'(mn_pop_rdy), 32'd0);
    do_pop();
    check_eq("pop_vld_empty", 32'(mn_pop_vld), 32'd0);

    // min ordering: F0(id0) 15(id1) 87(id2)
    do_push(8'hF0); do_push(8'h15); do_push(8'h87);
    check_eq("min_cnt3", 32'(mn_cnt), 32'd3);
    check_eq("min_peek", 32'(mn_peek_data), 32'h15);
    check_eq("min_peek_id", 32'(mn_peek_id), 32'd1);
    do_pop();
    check_eq("pop1_vld", 32'(mn_pop_vld), 32'd1);
    check_eq("pop1_data", 32'(mn_data_o), 32'h15);
    check_eq("pop1_id", 32'(mn_id_o), 32'd1);
    tick();
    check_eq("pop_vld_pulse", 32'(mn_pop_vld), 32'd0);
    check_eq("data_o_hold", 32'(mn_data_o), 32'h15);
    do_pop();
    check_eq("pop2_data", 32'(mn_data_o), 32'h87);
    check_eq("pop2_id", 32'(mn_id_o), 32'd2);
    do_pop();
    check_eq("pop3_data", 32'(mn_data_o), 32'hF0);
    check_eq("pop3_id", 32'(mn_id_o), 32'd0);
    check_eq("min_empty", 32'(mn_empty), 32'd1);

    // drop: 01(id0) EB(id1) AF(id2)
    do_push(8'h01); do_push(8'hEB);
    check_eq("push_id_next", 32'(mn_push_id), 32'd2);
    do_push(8'hAF);
    do_pop();
    check_eq("drop_pre_pop", 32'(mn_data_o), 32'h01);
    drop_min(4'd2, 1'b1, 4'd1);
    do_pop();
    check_eq("after_drop_pop", 32'(mn_data_o), 32'hEB);
    check_eq("after_drop_pop_id", 32'(mn_id_o), 32'd1);
    drop_min(4'd5, 1'b0, 4'd0);

    // full queue: 10..17 get ids 0..7
    for (int k = 0; k < 8; k++) do_push(8'(8'h10 + k));
    check_eq("full", 32'(mn_full), 32'd1);
    check_eq("full_cnt", 32'(mn_cnt), 32'd8);
    check_eq("full_push_id", 32'(mn_push_id), 32'd8);
    do_push(8'h05);
    check_eq("evict_ovf", 32'(mn_ovf), 32'd1);
    check_eq("evict_data", 32'(mn_ovf_data), 32'h17);
    check_eq("evict_id", 32'(mn_ovf_id), 32'd7);
    check_eq("evict_cnt", 32'(mn_cnt), 32'd8);
    check_eq("evict_peek", 32'(mn_peek_data), 32'h05);
    check_eq("evict_peek_id", 32'(mn_peek_id), 32'd8);
    tick();
    check_eq("ovf_pulse_end", 32'(mn_ovf), 32'd0);
    check_eq("freed_id", 32'(mn_push_id), 32'd7);
    do_push(8'hFF);
    check_eq("reject_ovf", 32'(mn_ovf), 32'd1);
    check_eq("reject_data", 32'(mn_ovf_data), 32'hFF);
    check_eq("reject_id", 32'(mn_ovf_id), 32'd7);
    check_eq("reject_cnt", 32'(mn_cnt), 32'd8);
    check_eq("reject_peek", 32'(mn_peek_data), 32'h05);

    // push+pop on full queue
    push_i = 1'b1; data_i = 8'h20; pop_i = 1'b1;
    tick();
    push_i = 1'b0; pop_i = 1'b0;
    check_eq("pp_vld", 32'(mn_pop_vld), 32'd1);
    check_eq("pp_data", 32'(mn_data_o), 32'h05);
    check_eq("pp_id", 32'(mn_id_o), 32'd8);
    check_eq("pp_cnt", 32'(mn_cnt), 32'd8);
    check_eq("pp_no_ovf", 32'(mn_ovf), 32'd0);
    for (int k = 0; k < 7; k++) exp_q.push_back(8'(8'h10 + k));
    exp_q.push_back(8'h20);
    while (exp_q.size() > 0) begin
      do_pop();
      check_eq("drain", 32'(mn_data_o), 32'(exp_q.pop_front()));
    end
    check_eq("drain_empty", 32'(mn_empty), 32'd1);

    // max mode with ties
    do_reset();
    do_push(8'h30); do_push(8'h30); do_push(8'h40);
    check_eq("max_peek", 32'(mx_peek_data), 32'h40);
    do_pop();
    check_eq("max_pop1", 32'(mx_data_o), 32'h40);
    check_eq("max_pop1_id", 32'(mx_id_o), 32'd2);
    check_eq("max_realloc2", 32'(mx_push_id), 32'd2);
    do_pop();
    check_eq("max_pop2", 32'(mx_data_o), 32'h30);
    check_eq("max_pop2_id", 32'(mx_id_o), 32'd0);
    check_eq("max_realloc0", 32'(mx_push_id), 32'd0);
    do_pop();
    check_eq("max_pop3", 32'(mx_data_o), 32'h30);
    check_eq("max_pop3_id", 32'(mx_id_o), 32'd1);
    check_eq("max_empty", 32'(mx_empty), 32'd1);

    // reset while in DROP_SRCH
    do_reset();
    do_push(8'h55); do_push(8'h55);
    drop_i = 1'b1; drop_id_i = 4'd1;
    tick();
    drop_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_eq("abort_empty", 32'(mn_empty), 32'd1);
    check_eq("abort_done", 32'(mn_done), 32'd0);
    tick();
    check_eq("abort_done2", 32'(mn_done), 32'd0);
    tick();
    check_eq("abort_done3", 32'(mn_done), 32'd0);
    do_push(8'h77);
    check_eq("abort_push_id", 32'(mn_peek_id), 32'd0);
    check_eq("abort_cnt", 32'(mn_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
